// File: rtl/req_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : req_arbiter_8
// Description : Eight-line rising-edge request capture with round-robin
//               arbitration. Presents one pending request at a time as a
//               registered one-hot grant with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module req_arbiter_8 #(
  parameter int NUM_REQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               out_ready,
  input  logic               ovf_clr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] pending_out,
  output logic [NUM_REQ-1:0] overflow_out
);

  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [NUM_REQ-1:0]   req_q;
  logic [NUM_REQ-1:0]   pending;
  logic [NUM_REQ-1:0]   overflow;
  logic [IDX_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   grant_d;
  logic                 valid;
  logic                 valid_d;

  logic [NUM_REQ-1:0]   rise;
  logic                 accept;
  logic [NUM_REQ-1:0]   acc_mask;
  logic [NUM_REQ-1:0]   cand;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     next_ptr;

  // Binary index of a one-hot word (grant is always one-hot when used).
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // First set bit of v searching base, base+1, ... with modulo-8 wrap.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDX_W-1:0]   base);
    logic [NUM_REQ-1:0] sel;
    logic               found;
    logic [IDX_W-1:0]   idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = base + IDX_W'(k);
      if (!found && v[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

  assign rise      = req_in & ~req_q;
  assign accept    = valid & out_ready;
  assign acc_mask  = accept ? grant : '0;
  // Arbitration candidates come only from the registered pending word.
  assign cand      = pending & ~acc_mask;
  assign grant_idx = onehot_idx(grant);
  assign next_ptr  = grant_idx + IDX_W'(1);

  // Edge detect, pending capture and sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      req_q    <= req_in;
      pending  <= cand | rise;
      overflow <= ovf_clr ? '0 : (overflow | (rise & pending & ~acc_mask));
    end
  end

  // Round-robin pointer moves past the accepted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= next_ptr;
    end
  end

  // FSM state and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      valid <= valid_d;
    end
  end

  // Next-state and next-grant selection; grant held stable until accepted.
  always_comb begin
    state_d = state;
    grant_d = grant;
    valid_d = valid;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          grant_d = rr_pick(pending, ptr);
          valid_d = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          if (|cand) begin
            grant_d = rr_pick(cand, next_ptr);
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign grant_onehot = grant;
  assign out_valid    = valid;
  assign pending_out  = pending;
  assign overflow_out = overflow;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_arbiter_8
// Description : Self-checking bench for req_arbiter_8 with directed scenarios
//               and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic       out_ready;
  logic       ovf_clr;
  logic [7:0] grant_onehot;
  logic       out_valid;
  logic [7:0] pending_out;
  logic [7:0] overflow_out;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [7:0] m_reqq;
  logic [7:0] m_pend;
  logic [7:0] m_ovf;
  int         m_ptr;
  int         m_gidx;
  bit         m_valid;

  // Fairness bookkeeping
  int         fair_got;
  logic [7:0] fair_prev;
  bit         fair_have;

  req_arbiter_8 #(.NUM_REQ(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .out_ready    (out_ready),
    .ovf_clr      (ovf_clr),
    .grant_onehot (grant_onehot),
    .out_valid    (out_valid),
    .pending_out  (pending_out),
    .overflow_out (overflow_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int first_from(input logic [7:0] v, input int base);
    for (int k = 0; k < 8; k++) begin
      if (v[(base + k) % 8]) return (base + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [7:0] m_grant();
    return m_valid ? 8'(1 << m_gidx) : 8'h00;
  endfunction

  task automatic model_reset();
    m_reqq  = 8'h00;
    m_pend  = 8'h00;
    m_ovf   = 8'h00;
    m_ptr   = 0;
    m_gidx  = 0;
    m_valid = 1'b0;
  endtask

  // One clock edge of the arbiter, computed from the behavioural rules.
  task automatic model_step(input logic [7:0] req, input bit rdy, input bit clr);
    logic [7:0] rise;
    logic [7:0] accm;
    logic [7:0] left;
    bit         acc;
    rise = req & ~m_reqq;
    acc  = m_valid && rdy;
    accm = acc ? 8'(1 << m_gidx) : 8'h00;
    left = m_pend & ~accm;
    if (!m_valid) begin
      if (m_pend != 8'h00) begin
        m_gidx  = first_from(m_pend, m_ptr);
        m_valid = 1'b1;
      end
    end else if (acc) begin
      m_ptr = (m_gidx + 1) % 8;
      if (left != 8'h00) m_gidx = first_from(left, m_ptr);
      else               m_valid = 1'b0;
    end
    m_ovf  = clr ? 8'h00 : (m_ovf | (rise & m_pend & ~accm));
    m_pend = left | rise;
    m_reqq = req;
  endtask

  task automatic compare_all();
    check_val("grant",    grant_onehot,        m_grant());
    check_val("valid",    {7'b0, out_valid},   {7'b0, m_valid});
    check_val("pending",  pending_out,         m_pend);
    check_val("overflow", overflow_out,        m_ovf);
  endtask

  // Called just after a falling edge: drive, clock, then compare.
  task automatic step(input logic [7:0] req, input bit rdy, input bit clr);
    req_in    = req;
    out_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    model_step(req, rdy, clr);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic reset_mid(input logic [7:0] hold_req);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_grant",    grant_onehot,      8'h00);
    check_val("rst_valid",    {7'b0, out_valid}, 8'h00);
    check_val("rst_pending",  pending_out,       8'h00);
    check_val("rst_overflow", overflow_out,      8'h00);
    req_in    = hold_req;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare_all();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_in    = 8'h00;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Single request
    step(8'h08, 1'b1, 1'b0);
    check_val("t1_pend", pending_out, 8'h08);
    step(8'h00, 1'b1, 1'b0);
    check_val("t1_grant", grant_onehot, 8'h08);
    check_val("t1_enc", {5'b0, enc(grant_onehot)}, 8'h03);
    step(8'h00, 1'b1, 1'b0);
    check_val("t1_idle", {7'b0, out_valid}, 8'h00);
    check_val("t1_pend0", pending_out, 8'h00);

    // Simultaneous requests with pointer wrap
    reset_mid(8'h00);
    step(8'h81, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    check_val("t2_first", grant_onehot, 8'h01);
    step(8'h00, 1'b1, 1'b0);
    check_val("t2_second", grant_onehot, 8'h80);
    step(8'h00, 1'b1, 1'b0);
    check_val("t2_idle", {7'b0, out_valid}, 8'h00);
    step(8'h81, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check_val("t2_ptr_wrap", grant_onehot, 8'h01);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);

    // Fairness between bits 0 and 1
    fair_got  = 0;
    fair_prev = 8'h00;
    fair_have = 1'b0;
    for (int c = 0; c < 40 && fair_got < 6; c++) begin
      step((c % 2 == 0) ? 8'h03 : 8'h00, 1'b1, 1'b0);
      if (out_valid) begin
        if (fair_have)
          check_val("fair_alt", (grant_onehot == fair_prev) ? 8'h01 : 8'h00, 8'h00);
        fair_prev = grant_onehot;
        fair_have = 1'b1;
        fair_got++;
      end
    end
    check_val("fair_count", fair_got[7:0], 8'd6);
    repeat (3) step(8'h00, 1'b1, 1'b0);

    // Backpressure
    reset_mid(8'h00);
    step(8'h04, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step((i % 2 == 0) ? 8'h10 : 8'h00, 1'b0, 1'b0);
      check_val("bp_grant", grant_onehot, 8'h04);
      check_val("bp_valid", {7'b0, out_valid}, 8'h01);
    end
    check_val("bp_pend", pending_out, 8'h14);
    step(8'h00, 1'b1, 1'b0);
    check_val("bp_next", grant_onehot, 8'h10);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b1);

    // Overflow, clear, and rise during accept
    reset_mid(8'h00);
    step(8'h04, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    check_val("ovf_set", overflow_out, 8'h04);
    step(8'h00, 1'b0, 1'b1);
    check_val("ovf_clr", overflow_out, 8'h00);
    step(8'h04, 1'b1, 1'b0);
    check_val("acc_rise_pend", pending_out & 8'h04, 8'h04);
    check_val("acc_rise_ovf", overflow_out & 8'h04, 8'h00);
    step(8'h00, 1'b1, 1'b0);
    check_val("acc_rise_regrant", grant_onehot, 8'h04);
    step(8'h00, 1'b1, 1'b0);

    // Reset mid-grant with a line held high through release
    step(8'hF0, 1'b0, 1'b0);
    step(8'hF0, 1'b0, 1'b0);
    check_val("pre_rst_pend", pending_out, 8'hF0);
    check_val("pre_rst_valid", {7'b0, out_valid}, 8'h01);
    reset_mid(8'h20);
    step(8'h20, 1'b0, 1'b0);
    check_val("post_rst_pend", pending_out, 8'h20);
    step(8'h20, 1'b1, 1'b0);
    check_val("post_rst_grant", grant_onehot, 8'h20);
    step(8'h00, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0)
        reset_mid(8'($urandom));
      step(8'($urandom & $urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/req_arbiter_8.md
# req_arbiter_8

Eight-input request capture and round-robin arbitration stage that sits directly upstream of the 8x3 gate-level encoder. It detects rising edges on eight request lines and latches them as pending. It selects one pending request at a time and presents it as a stable one-hot `grant_onehot` word, with a valid/ready handshake. `grant_onehot` drives the encoder's `data_in`, so the encoder only ever sees a legal one-hot or all-zero code.

## Interface
- `NUM_REQ`, 8: number of request lines. Fixed at 8 to match the 8x3 encoder; any other value is unsupported.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low).
- `req_in` in 8: request lines, synchronous to `clk`. Only a rising edge creates a request.
- `out_ready` in 1: consumer accepts the current grant when high together with `out_valid`.
- `ovf_clr` in 1: single-cycle pulse that clears all `overflow_out` bits.
- `grant_onehot` out 8: granted request, one-hot. All zero when `out_valid`=0.
- `out_valid` out 1: `grant_onehot` holds a valid grant.
- `pending_out` out 8: current pending-request register.
- `overflow_out` out 8: sticky per-bit flag. Set when a new rising edge hits a bit that is already pending and is not being accepted that cycle.

## Operation
- Edge detect: `req_q <= req_in`; `rise = req_in & ~req_q`.
  - `req_q` resets to 0, so a line held high through reset release produces a request on the first edge. This is intended.
- Pending update each edge: `pending <= (pending & ~acc_mask) | rise`.
  - `acc_mask` is `grant_onehot` when `out_valid & out_ready`, else 0.
  - A rise on the bit being accepted in the same cycle leaves that bit pending (new event; not lost, not an overflow).
- Overflow: `overflow <= ovf_clr ? 0 : overflow | (rise & pending & ~acc_mask)`.
  - `ovf_clr` wins over a simultaneous set.
- Round-robin pointer `ptr` (3 bits):
  - Search order: `ptr`, `ptr+1`, ... wrapping modulo 8.
  - On accept of index i, `ptr <= (i+1) mod 8`. Wrap from 7 goes to 0.
- FSM, two states:
  - IDLE: `out_valid`=0, `grant_onehot`=0. If `pending != 0`, load the first pending bit in search order into `grant_onehot`, set `out_valid`, go to GRANT.
  - GRANT: `grant_onehot` and `out_valid` held stable while `out_ready`=0. On `out_valid & out_ready`:
    - If `(pending & ~acc_mask) != 0`, load the next winner (search from the updated pointer) and stay in GRANT (back-to-back).
    - Otherwise clear `out_valid`/`grant_onehot` and go to IDLE.
- Requests arriving during GRANT never change the current grant. They only join `pending`.
- Arbitration uses only the registered `pending` (including bits set by `rise` on the previous edge), never the same-cycle `rise`.

## Timing
- Reset values: `grant_onehot`=0, `out_valid`=0, `pending_out`=0, `overflow_out`=0, `ptr`=0, `req_q`=0, FSM=IDLE.
  - Reset assertion mid-grant drops `out_valid` immediately (asynchronously) and discards all pending requests.
- Latency: `req_in` rise sampled at edge k gives `pending_out` bit set after edge k, and `out_valid`/`grant_onehot` after edge k+1 when the block is IDLE.
- Throughput: one grant per cycle when `out_ready` is held high and requests are pending.
- After an accept at edge a, `pending_out` shows the cleared bit after edge a.
- Outputs are registered; there is no combinational path from `req_in` or `out_ready` to any output.

## Test plan
- Single request: after reset, pulse `req_in`=8'h08 for one cycle, `out_ready`=1. Required:
  - `pending_out`=8'h08 one edge later.
  - `out_valid`=1 and `grant_onehot`=8'h08 the next edge; downstream encoder outputs 3'b011.
  - Returns to IDLE with `pending_out`=0 after accept.
- Simultaneous requests: `req_in` 0 -> 8'h81 with `ptr`=0, `out_ready`=1. Required: grants 8'h01 then 8'h80 on consecutive cycles, then `out_valid`=0 and `ptr`=0 (wrap from 7).
- Fairness: bits 0 and 1 re-pulsed after every grant for 6 grants. Required: grants alternate 8'h01, 8'h02, 8'h01, ... Neither bit is granted twice in a row.
- Backpressure: grant 8'h04 valid, `out_ready`=0 for 5 cycles while `req_in` pulses 8'h10. Required:
  - `grant_onehot` stays 8'h04 and `out_valid` stays 1.
  - `pending_out`=8'h14.
  - On `out_ready`=1, the next grant is 8'h10.
- Overflow: with `out_ready`=0, pulse bit 2 twice. Required:
  - `overflow_out`=8'h04 after the second rise.
  - `ovf_clr` pulse returns it to 0.
  - A rise on bit 2 in the same cycle it is accepted leaves `pending_out[2]`=1 and `overflow_out[2]`=0.
- Reset mid-operation: assert `rst_n`=0 between clock edges while `out_valid`=1 and `pending_out`=8'hF0. Required: all outputs 0 immediately, before the next edge. After release, no grant until a new rise, except lines held high, which request on the first edge.
